// File: rtl/run_ctrl_pkg.sv
// Shared types and width helpers for the run controller.
// No logic of its own; imported by the sequencer and its release sub-block.
// No flow control.
package run_ctrl_pkg;

    // Top-level sequencer phases: idle, global reset hold, staggered release, run, done.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOLD    = 3'd1,
        RELEASE = 3'd2,
        RUN     = 3'd3,
        FINISH  = 3'd4
    } state_t;

    // Width needed to hold the values 0..max. Never returns less than 1 bit.
    function automatic int cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/run_ctrl_sequencer_stagger_release.sv
// Staggered reset release: phase counter plus per-channel compare driving registered resets.
// Latency: channel k deasserts RESET_CYCLES + k*STAGGER edges after the start strobe.
// No backpressure; counts only while i_active, holds otherwise.
module stagger_release
    import run_ctrl_pkg::*;
#(
    parameter int N_CH         = 3,
    parameter int RESET_CYCLES = 4,
    parameter int STAGGER      = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic            i_active,
    output logic [N_CH-1:0] o_reset,
    output logic            o_first,
    output logic            o_last
);

    // Phase at which the last channel is released; the counter never passes it.
    localparam int PH_MAX = RESET_CYCLES + (N_CH - 1) * STAGGER;
    localparam int PH_W   = cnt_w(PH_MAX);

    logic [PH_W-1:0] phase_q, phase_d;
    logic [N_CH-1:0] rst_q, rst_d;
    int              next_ph;

    // Phase the counter will hold after the coming edge, evaluated in full int width.
    assign next_ph = int'(phase_q) + 1;

    // The coming edge releases channel 0 / the last channel (the FSM keys its transitions off these).
    assign o_first = i_active && (next_ph == RESET_CYCLES);
    assign o_last  = i_active && (next_ph == PH_MAX);

    // Start rearms every channel; while active each channel drops once its release phase is reached.
    always_comb begin
        phase_d = phase_q;
        rst_d   = rst_q;
        if (i_start) begin
            phase_d = '0;
            rst_d   = '1;
        end else if (i_active) begin
            phase_d = PH_W'(next_ph);
            for (int k = 0; k < N_CH; k++) begin
                if (next_ph >= RESET_CYCLES + k * STAGGER) begin
                    rst_d[k] = 1'b0;
                end
            end
        end
    end

    // Registered phase and reset vector; reset asserts every channel.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            phase_q <= '0;
            rst_q   <= '1;
        end else begin
            phase_q <= phase_d;
            rst_q   <= rst_d;
        end
    end

    assign o_reset = rst_q;

endmodule

// File: rtl/run_ctrl_sequencer.sv
// Run controller: reset hold, staggered per-channel release, run-cycle count, done/timeout finish.
// Latency: start accepted on its edge; first release RESET_CYCLES edges later; all outputs registered.
// No backpressure; optional RUN_CTRL_PAUSE_EN adds i_pause to freeze the run counter.
module run_ctrl_sequencer
    import run_ctrl_pkg::*;
#(
    parameter int N_CH           = 3,
    parameter int RESET_CYCLES   = 4,
    parameter int STAGGER        = 2,
    parameter int TIMEOUT_CYCLES = 40,
    localparam int CYC_W         = cnt_w(TIMEOUT_CYCLES)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [N_CH-1:0]  i_done,
`ifdef RUN_CTRL_PAUSE_EN
    input  logic             i_pause,
`endif
    output logic [N_CH-1:0]  o_reset,
    output logic             o_running,
    output logic             o_finished,
    output logic             o_timeout,
    output logic [CYC_W-1:0] o_cycles
);

    state_t           state_q, state_d;
    logic [CYC_W-1:0] cycles_q, cycles_d;
    logic [N_CH-1:0]  sticky_q, sticky_d;
    logic             timeout_q, timeout_d;
    logic             start_go;
    logic             active;
    logic             rel_first;
    logic             rel_last;
    logic             done_all;
    logic             pause;

`ifdef RUN_CTRL_PAUSE_EN
    assign pause = i_pause;
`else
    assign pause = 1'b0;
`endif

    // Start is only honoured from IDLE or FINISH; the release block counts during HOLD and RELEASE.
    assign start_go = i_start && ((state_q == IDLE) || (state_q == FINISH));
    assign active   = (state_q == HOLD) || (state_q == RELEASE);
    // Current-cycle done flags count together with those already captured.
    assign done_all = &(sticky_q | i_done);

    stagger_release #(
        .N_CH         (N_CH),
        .RESET_CYCLES (RESET_CYCLES),
        .STAGGER      (STAGGER)
    ) u_release (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_start  (start_go),
        .i_active (active),
        .o_reset  (o_reset),
        .o_first  (rel_first),
        .o_last   (rel_last)
    );

    // Sequencer next state: done beats timeout, pause freezes the counter but not done capture.
    always_comb begin
        state_d   = state_q;
        cycles_d  = cycles_q;
        sticky_d  = sticky_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE, FINISH: begin
                if (start_go) begin
                    state_d   = HOLD;
                    cycles_d  = '0;
                    sticky_d  = '0;
                    timeout_d = 1'b0;
                end
            end
            HOLD: begin
                if (rel_first) begin
                    state_d = rel_last ? RUN : RELEASE;
                end
            end
            RELEASE: begin
                if (rel_last) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                sticky_d = sticky_q | i_done;
                if (done_all) begin
                    state_d   = FINISH;
                    timeout_d = 1'b0;
                end else if (!pause) begin
                    if (cycles_q == CYC_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d   = FINISH;
                        timeout_d = 1'b1;
                    end else begin
                        cycles_d = cycles_q + CYC_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer registers; reset aborts any run and clears all status.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            cycles_q  <= '0;
            sticky_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycles_q  <= cycles_d;
            sticky_q  <= sticky_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_running  = (state_q == RUN);
    assign o_finished = (state_q == FINISH);
    assign o_timeout  = timeout_q;
    assign o_cycles   = cycles_q;

endmodule

// File: tb/tb_run_ctrl_sequencer.sv
// Directed bench for run_ctrl_sequencer with a timeline-based reference model and literal checkpoints.
// Edge n is the n-th rising clock edge; outputs are checked on the falling edge after it.
// Inputs are changed on falling edges only.
module tb_run_ctrl_sequencer;

    localparam int N_CH  = 3;
    localparam int RC    = 4;
    localparam int ST    = 2;
    localparam int TO    = 40;
    localparam int CYC_W = 6;
    localparam int LAST  = RC + (N_CH - 1) * ST;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [N_CH-1:0]  done = '0;
    logic             pause = 1'b0;
    logic [N_CH-1:0]  o_reset;
    logic             o_running;
    logic             o_finished;
    logic             o_timeout;
    logic [CYC_W-1:0] o_cycles;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;

    // Reference model: a run is described by its start edge and the run-cycle count.
    bit              m_busy = 1'b0;
    bit              m_fin  = 1'b0;
    bit              m_to   = 1'b0;
    int              t0     = 0;
    int              m_cyc  = 0;
    bit [N_CH-1:0]   m_sticky = '0;

    run_ctrl_sequencer dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_start    (start),
        .i_done     (done),
`ifdef RUN_CTRL_PAUSE_EN
        .i_pause    (pause),
`endif
        .o_reset    (o_reset),
        .o_running  (o_running),
        .o_finished (o_finished),
        .o_timeout  (o_timeout),
        .o_cycles   (o_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    endtask

    // Model update on each edge, from inputs set on the preceding falling edge.
    always @(posedge clk) begin
        bit all_done;
        edge_n++;
        if (rst) begin
            m_busy = 0; m_fin = 0; m_to = 0; m_cyc = 0; m_sticky = '0;
        end else if (!m_busy && start) begin
            m_busy = 1; m_fin = 0; m_to = 0; m_cyc = 0; m_sticky = '0; t0 = edge_n;
        end else if (m_busy && edge_n > t0 + LAST) begin
            all_done = &(m_sticky | done);
            m_sticky = m_sticky | done;
            if (all_done) begin
                m_busy = 0; m_fin = 1; m_to = 0;
            end else if (!pause) begin
                if (m_cyc == TO - 1) begin
                    m_busy = 0; m_fin = 1; m_to = 1;
                end else begin
                    m_cyc++;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [N_CH-1:0] e_rst;
        if (edge_n >= 1) begin
            for (int k = 0; k < N_CH; k++)
                e_rst[k] = !(m_busy || m_fin) ? 1'b1 : (edge_n < t0 + RC + k * ST);
            chk("model_reset",    32'(o_reset),    32'(e_rst));
            chk("model_running",  32'(o_running),  32'(m_busy && edge_n >= t0 + LAST));
            chk("model_finished", 32'(o_finished), 32'(m_fin));
            chk("model_timeout",  32'(o_timeout),  32'(m_to));
            chk("model_cycles",   32'(o_cycles),   32'(m_cyc));
        end
    end

    task automatic at_edge(input int n);
        while (edge_n < n) @(negedge clk);
    endtask

    initial begin
        // Reset for edges 1..3, start sampled at edge 5.
        at_edge(3);
        chk("lit_rst_reset", 32'(o_reset), 32'h7);
        chk("lit_rst_cycles", 32'(o_cycles), 32'd0);
        rst = 1'b0;
        at_edge(4);  start = 1'b1;
        at_edge(5);  start = 1'b0;
        at_edge(8);  chk("lit_hold_e8", 32'(o_reset), 32'h7);
        at_edge(9);  chk("lit_rel0_e9", 32'(o_reset), 32'h6);
        at_edge(11); chk("lit_rel1_e11", 32'(o_reset), 32'h4);
        at_edge(12); chk("lit_notrun_e12", 32'(o_running), 32'd0);
        at_edge(13); chk("lit_rel2_e13", 32'(o_reset), 32'h0);
        chk("lit_run_e13", 32'(o_running), 32'd1);
        chk("lit_cyc0_e13", 32'(o_cycles), 32'd0);

        // Done-driven finish: 001 at run cycle 5, 110 at run cycle 9.
        at_edge(18); done = 3'b001;
        at_edge(19); done = 3'b000;
        at_edge(22); done = 3'b110;
        at_edge(23); done = 3'b000;
        chk("lit_done_fin", 32'(o_finished), 32'd1);
        chk("lit_done_to", 32'(o_timeout), 32'd0);
        chk("lit_done_cyc", 32'(o_cycles), 32'd9);

        // Timeout with done stuck at 011; restart from FINISH at edge 26, run from 34.
        at_edge(25); start = 1'b1; done = 3'b011;
        at_edge(26); start = 1'b0;
        chk("lit_restart_reset", 32'(o_reset), 32'h7);
        chk("lit_restart_fin", 32'(o_finished), 32'd0);
        chk("lit_restart_cyc", 32'(o_cycles), 32'd0);
        at_edge(73); chk("lit_to_cyc39", 32'(o_cycles), 32'd39);
        chk("lit_to_notfin", 32'(o_finished), 32'd0);
        at_edge(74); chk("lit_to_fin", 32'(o_finished), 32'd1);
        chk("lit_to_to", 32'(o_timeout), 32'd1);
        chk("lit_to_cyc", 32'(o_cycles), 32'd39);
        done = 3'b000;

        // Done and timeout coincide: start sampled at 80, run from 88, all done at cycle 39.
        at_edge(79); start = 1'b1;
        at_edge(80); start = 1'b0;
        at_edge(127); done = 3'b111;
        at_edge(128); done = 3'b000;
        chk("lit_tie_fin", 32'(o_finished), 32'd1);
        chk("lit_tie_to", 32'(o_timeout), 32'd0);
        chk("lit_tie_cyc", 32'(o_cycles), 32'd39);

        // Mid-run disturbances: start at cycle 10 ignored, reset at cycle 12 aborts.
        at_edge(131); start = 1'b1;
        at_edge(132); start = 1'b0;
        at_edge(133); start = 1'b1;
        at_edge(134); start = 1'b0;
        at_edge(150); start = 1'b1;
        at_edge(151); start = 1'b0;
        chk("lit_ign_run", 32'(o_running), 32'd1);
        chk("lit_ign_cyc", 32'(o_cycles), 32'd11);
        at_edge(152); rst = 1'b1;
        at_edge(153); rst = 1'b0;
        chk("lit_abort_reset", 32'(o_reset), 32'h7);
        chk("lit_abort_run", 32'(o_running), 32'd0);
        chk("lit_abort_cyc", 32'(o_cycles), 32'd0);

`ifdef RUN_CTRL_PAUSE_EN
        // Pause for 10 edges during the run; timeout lands 10 edges late.
        at_edge(159); start = 1'b1;
        at_edge(160); start = 1'b0;
        at_edge(173); pause = 1'b1;
        at_edge(183); pause = 1'b0;
        chk("lit_pause_cyc", 32'(o_cycles), 32'd5);
        at_edge(217); chk("lit_pause_notfin", 32'(o_finished), 32'd0);
        at_edge(218); chk("lit_pause_fin", 32'(o_finished), 32'd1);
        chk("lit_pause_to", 32'(o_timeout), 32'd1);
        chk("lit_pause_end", 32'(o_cycles), 32'd39);
`endif

        at_edge(edge_n + 3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/run_ctrl_sequencer.md
Name: run_ctrl_sequencer

Overview:
- Synthesizable run controller for lab designs and on-board self-tests.
- Generates a parametrised reset hold, then releases N reset channels one after another in a staggered order.
- Counts run cycles, collects per-channel done flags and reports finish or timeout.
- Sits between top-level board control (button or start pulse) and the DUT reset inputs.

Parameters:
N_CH, 3, number of reset channels/domains (>=1)
RESET_CYCLES, 4, cycles all resets stay asserted after start (>=1)
STAGGER, 2, cycles between consecutive channel releases (>=0)
TIMEOUT_CYCLES, 40, maximum RUN cycles before timeout (>=1)

Ports:
i_clk  in  1  clock; all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_start  in  1  start/restart request, sampled each edge
i_done  in  N_CH  per-channel done flags from the DUT
o_reset  out  N_CH  active-high reset per channel
o_running  out  1  high while in RUN
o_finished  out  1  high in FINISH
o_timeout  out  1  FINISH reached by timeout
o_cycles  out  CYC_W  RUN cycle count; CYC_W = $clog2(TIMEOUT_CYCLES+1)

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high; the ports are named i_clk and i_reset.
- While i_reset=1 (at each edge): state IDLE, o_reset all 1s, o_running=0, o_finished=0, o_timeout=0, o_cycles=0, done-sticky register=0.
  - Reset wins over every other input in the same cycle.
  - Reset mid-operation aborts immediately.
- IDLE:
  - o_reset all 1s.
  - i_start=1 at edge t -> HOLD at t; internal counter cleared.
- HOLD:
  - All resets stay asserted for exactly RESET_CYCLES cycles.
  - At edge t+RESET_CYCLES, o_reset[0] goes 0.
  - Next state is RELEASE, or RUN if N_CH=1 or STAGGER=0.
- RELEASE:
  - o_reset[k] goes 0 at edge t+RESET_CYCLES+k*STAGGER.
  - When STAGGER=0, all channels go 0 on the same edge.
  - RUN is entered on the edge that releases channel N_CH-1.
  - Released channels never re-assert before a restart.
- RUN:
  - o_running=1.
  - o_cycles is 0 in the first RUN cycle and increments by 1 per cycle.
  - done_sticky |= i_done each cycle.
  - If (done_sticky | i_done) is all ones at an edge: -> FINISH, o_timeout=0.
  - Else if o_cycles == TIMEOUT_CYCLES-1 at an edge: -> FINISH, o_timeout=1.
  - Done and timeout in the same cycle: done wins, o_timeout=0.
- FINISH:
  - o_running=0, o_finished=1; o_cycles frozen at its final value; resets stay deasserted.
  - i_start=1 -> HOLD next edge: o_reset all 1s, o_finished/o_timeout/o_cycles/done_sticky cleared on that edge.
- i_start in HOLD, RELEASE or RUN is ignored.
- i_done outside RUN is ignored.
- Width rules:
  - Internal phase counter width = $clog2(RESET_CYCLES + (N_CH-1)*STAGGER + 1).
  - No wrap is possible; o_cycles cannot exceed TIMEOUT_CYCLES-1.
- All outputs are registered; no combinational input-to-output paths.

Optional Feature:
- Macro: RUN_CTRL_PAUSE_EN.
- Defined:
  - Adds input i_pause (1 bit).
  - In RUN, i_pause=1 holds o_cycles, so the timeout does not advance.
  - Done flags are still captured, and a done-driven finish still occurs while paused.
  - i_pause has no effect in other states.
- Undefined: the port is absent; o_cycles always advances in RUN.

Decomposition:
- Package run_ctrl_pkg holds:
  - enum state_t {IDLE, HOLD, RELEASE, RUN, FINISH};
  - width helper function cnt_w(max) = $clog2(max+1).
- One sub-module, stagger_release:
  - phase counter plus per-channel compare;
  - produces the o_reset vector from a start strobe and the phase count.
- The top FSM is in run_ctrl_sequencer.

Test Plan:
- Start, reset hold and release (defaults):
  - Stimulus: i_reset high 3 cycles, then i_start pulse at edge 5.
  - Response: o_reset=3'b111 through edge 8; bit0 low at edge 9, bit1 at 11, bit2 at 13; o_running=1 from edge 13.
- Done-driven finish:
  - Stimulus: i_done=3'b001 at RUN cycle 5, 3'b110 at RUN cycle 9 (not simultaneous).
  - Response: FINISH at the following edge, o_timeout=0, o_cycles=9.
- Timeout:
  - Stimulus: i_done held at 3'b011 for the whole run.
  - Response: FINISH after o_cycles=39, o_timeout=1, o_finished=1.
- Done and timeout coincide:
  - Stimulus: all done bits arrive first at o_cycles=39.
  - Response: o_timeout=0.
- Mid-run disturbances:
  - i_start at RUN cycle 10 -> ignored.
  - i_reset at RUN cycle 12 -> next edge IDLE, o_reset=3'b111, all flags 0.
- Pause (RUN_CTRL_PAUSE_EN defined):
  - Stimulus: i_pause high for 10 cycles during RUN.
  - Response: timeout occurs 10 cycles later than without pause; o_cycles still ends at 39.
